clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Runtime-programmable integer clock divider, 50% duty for even and odd ratios.
//  Ratio changes are double-buffered and take effect only on a period boundary,
//  so clk_out never glitches. Adds enable with clean start/stop.
//  Sits between the system clock and slow peripheral clock domains (UART/SPI baud).
// PARAMETERS
//  WIDTH          4   ratio/counter width; legal ratio 2..2^WIDTH-1
//  DEFAULT_RATIO  2   ratio active after reset; must be 2..2^WIDTH-1
// PORTS
//  clock      in   1      source clock
//  reset_n    in   1      asynchronous, active-low reset
//  enable     in   1      run request, sampled on posedge clock
//  load       in   1      1-cycle strobe: request div_ratio as new ratio
//  div_ratio  in   WIDTH  requested ratio, valid with load
//  clk_out    out  1      divided clock
//  active     out  1      1 while divider in RUN or DRAIN
//  cur_ratio  out  WIDTH  ratio currently in use
//  ratio_ack  out  1      1-cycle pulse: pending ratio adopted
//  ratio_err  out  1      1-cycle pulse: load rejected (div_ratio < 2)
// BEHAVIOUR
//  Reset (async, immediate): clk_out=0, active=0, ratio_ack=0, ratio_err=0,
//   cur_ratio=DEFAULT_RATIO, no pending ratio, cnt=0, state IDLE.
//  Core: cnt counts 0..N-1 on posedge (N=cur_ratio); boundary = posedge where cnt==N-1.
//   p (posedge flop) = 1 while cnt in [0, floor(N/2)-1].
//   n (negedge flop) = p delayed by half a cycle.
//   clk_out = p for even N; clk_out = p|n for odd N.
//   Even N: N/2 cycles high. Odd N: (N-1)/2+0.5 cycles high, falls on negedge.
//   clk_out rises clock-to-q after the posedge that sets cnt to 0.
//  FSM:
//   IDLE  : enable=1 at posedge -> RUN, cnt<=0, p<=1, active<=1 (same edge).
//   RUN   : enable=0 mid-period -> DRAIN. Boundary with enable=0 -> IDLE.
//   DRAIN : finish current period. Boundary -> IDLE, cnt<=0, p stays 0,
//           active<=0. enable=1 again in DRAIN -> RUN, no gap or extra pulse.
//  Ratio load:
//   load with div_ratio>=2 -> pending<=div_ratio; newer load overwrites pending.
//   load with div_ratio<2  -> ratio_err pulse next cycle; pending unchanged.
//   Adoption: at a boundary in RUN/DRAIN, or at the next posedge in IDLE.
//    cur_ratio<=pending, ratio_ack pulses 1 cycle, new period uses new N.
//   load on the adoption edge itself -> div_ratio adopted directly (bypass).
//   Output never shows a partial old/new period.
//  Width: cnt and comparisons WIDTH bits, no overflow (N<=2^WIDTH-1).
//   floor(N/2) is N>>1.
//  Reset mid-period: clk_out drops asynchronously; pending load discarded.
// TESTING
//  1 reset, enable=1, DEFAULT_RATIO=2 -> clk_out period 2, high 1 cycle, cur_ratio=2.
//  2 load 3 then load 5, same period -> one ratio_ack at boundary; cur_ratio=5;
//    clk_out high 2.5 cycles, period 5.
//  3 load 0 and load 1 -> ratio_err pulse each; cur_ratio and pending unchanged.
//  4 N=6, drop enable at cnt=1 -> full 6-cycle period completes, then clk_out=0 and
//    active=0; re-enable inside DRAIN -> continuous waveform.
//  5 WIDTH=4, load 15 -> period 15, high 7.5 cycles; load on boundary edge
//    -> adopted that edge.
//  6 reset_n low mid-high-phase -> clk_out=0 immediately; after release
//    cur_ratio=DEFAULT_RATIO, state IDLE.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd ratios.
// Ratio changes are double-buffered and adopted only on period boundaries.
module clk_div_prog #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned DEFAULT_RATIO = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_ratio,
    output logic             clk_out,
    output logic             active,
    output logic [WIDTH-1:0] cur_ratio,
    output logic             ratio_ack,
    output logic             ratio_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(DEFAULT_RATIO);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_ratio_q, cur_ratio_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             p_q, p_d;
    logic             n_q, n_d;
    logic             active_q, active_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             boundary;
    logic             adopt_edge;
    logic [WIDTH-1:0] cnt_inc;

    always_comb begin
        load_ok     = load && (div_ratio >= WIDTH'(2));
        boundary    = (state_q != IDLE) && (cnt_q == cur_ratio_q - 1'b1);
        adopt_edge  = boundary || (state_q == IDLE);
        cnt_inc     = cnt_q + 1'b1;

        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        active_d    = active_q;
        cur_ratio_d = cur_ratio_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        ack_d       = 1'b0;
        err_d       = load && !load_ok;
        n_d         = p_q;

        // A load landing on the adoption edge bypasses the pending register.
        if (adopt_edge) begin
            if (load_ok) begin
                cur_ratio_d = div_ratio;
                ack_d       = 1'b1;
                pend_vld_d  = 1'b0;
            end else if (pend_vld_q) begin
                cur_ratio_d = pend_q;
                ack_d       = 1'b1;
                pend_vld_d  = 1'b0;
            end
        end else if (load_ok) begin
            pend_d     = div_ratio;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    p_d      = 1'b1;
                    active_d = 1'b1;
                end
            end
            default: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d  = RUN;
                        p_d      = 1'b1;
                        active_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        p_d      = 1'b0;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    p_d     = cnt_inc < (cur_ratio_q >> 1);
                    state_d = enable ? RUN : DRAIN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= 1'b0;
            active_q    <= 1'b0;
            cur_ratio_q <= RESET_RATIO;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            active_q    <= active_d;
            cur_ratio_q <= cur_ratio_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    // Half-cycle extension of the high phase, used only for odd ratios.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            n_q <= 1'b0;
        end else begin
            n_q <= n_d;
        end
    end

    assign clk_out   = cur_ratio_q[0] ? (p_q | n_q) : p_q;
    assign active    = active_q;
    assign cur_ratio = cur_ratio_q;
    assign ratio_ack = ack_q;
    assign ratio_err = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: expected pulses/acks/errs are queued by the
// stimulus and popped by independent monitors as the DUT produces them.
module tb_clk_div_prog;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic [3:0] div_ratio;
    logic       clk_out;
    logic       active;
    logic [3:0] cur_ratio;
    logic       ratio_ack;
    logic       ratio_err;

    clk_div_prog #(.WIDTH(4), .DEFAULT_RATIO(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .load      (load),
        .div_ratio (div_ratio),
        .clk_out   (clk_out),
        .active    (active),
        .cur_ratio (cur_ratio),
        .ratio_ack (ratio_ack),
        .ratio_err (ratio_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        longint high;
        longint per;
    } pulse_t;

    pulse_t pulse_q[$];
    int     ack_q[$];
    int     err_q[$];
    int     errors = 0;
    int     checks = 0;
    longint base   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_pulse(input longint high, input longint per);
        pulse_t e;
        e.high = high;
        e.per  = per;
        pulse_q.push_back(e);
    endtask

    task automatic wait_until(input longint t);
        if (t > $time) #(t - $time);
    endtask

    // Negedge just before posedge number k of the current run.
    task automatic at_s(input int k);
        wait_until(base + 10 * k - 5);
    endtask

    // clk_out waveform monitor: per pulse, high time and rise-to-rise period.
    longint last_rise = 0;
    longint prev_rise = 0;
    bit     seen_rise = 1'b0;

    always @(posedge clk_out) begin
        prev_rise = last_rise;
        last_rise = $time;
        seen_rise = 1'b1;
    end

    always @(negedge clk_out) begin
        if (seen_rise) begin
            pulse_t e;
            seen_rise = 1'b0;
            if (pulse_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse rising at t=%0d, expected none", last_rise);
            end else begin
                e = pulse_q.pop_front();
                check("pulse_high", $time - last_rise, e.high);
                if (e.per != 0) check("pulse_period", last_rise - prev_rise, e.per);
            end
        end
    end

    // Strobe monitor: every ack/err cycle must match a queued expectation.
    always @(negedge clock) begin
        if (ratio_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with cur_ratio=%0d, expected none", cur_ratio);
            end else begin
                check("ack_ratio", cur_ratio, ack_q.pop_front());
            end
        end
        if (ratio_err === 1'b1) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_err: got err at t=%0t, expected none", $time);
            end else begin
                check("err_cur_ratio", cur_ratio, err_q.pop_front());
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        div_ratio = '0;
        #12;
        reset_n = 1'b1;
        @(negedge clock);

        check("rst_clk_out", clk_out, 0);
        check("rst_active", active, 0);
        check("rst_cur_ratio", cur_ratio, 2);
        check("rst_ack", ratio_ack, 0);
        check("rst_err", ratio_err, 0);

        base = $time + 5;

        // Default ratio 2, then pending 6 adopted at the next boundary.
        at_s(0);  enable = 1'b1;
        exp_pulse(10, 0); exp_pulse(10, 20); exp_pulse(10, 20); exp_pulse(30, 20);
        at_s(1);  check("run_active", active, 1); check("run_cur_ratio", cur_ratio, 2);
        at_s(5);  load = 1'b1; div_ratio = 4'd6; ack_q.push_back(6);
        at_s(6);  load = 1'b0;

        // Two loads in one period: only the latest (5) is adopted.
        at_s(7);  load = 1'b1; div_ratio = 4'd3;
        at_s(8);  div_ratio = 4'd5; ack_q.push_back(5);
        at_s(9);  load = 1'b0;
        exp_pulse(25, 60);

        // Illegal ratios are rejected and leave the ratio alone.
        at_s(13); load = 1'b1; div_ratio = 4'd0; err_q.push_back(5);
        at_s(14); load = 1'b0;
        at_s(15); load = 1'b1; div_ratio = 4'd1; err_q.push_back(5);
        at_s(16); load = 1'b0;
        exp_pulse(25, 50); exp_pulse(25, 50);
        at_s(19); check("err_keeps_ratio", cur_ratio, 5);

        // N=6 with enable dropped at cnt=1: period completes then stops.
        at_s(23); load = 1'b1; div_ratio = 4'd6; ack_q.push_back(6);
        at_s(24); load = 1'b0;
        exp_pulse(30, 50);
        at_s(29); enable = 1'b0;
        at_s(31); check("drain_active", active, 1);
        at_s(35); check("stop_active", active, 0); check("stop_clk_out", clk_out, 0);

        // Restart, then drop and re-raise enable inside DRAIN: no gap.
        at_s(36); enable = 1'b1;
        exp_pulse(30, 0); exp_pulse(30, 60);
        at_s(38); enable = 1'b0;
        at_s(40); check("drain2_active", active, 1); enable = 1'b1;

        // Load 15 exactly on the boundary edge: adopted on that edge.
        at_s(48); load = 1'b1; div_ratio = 4'd15; ack_q.push_back(15);
        at_s(49); load = 1'b0;
        exp_pulse(75, 60);
        exp_pulse(27, 150);
        at_s(50); check("max_cur_ratio", cur_ratio, 15);

        // Pending load followed by reset mid-high-phase.
        at_s(64); load = 1'b1; div_ratio = 4'd9;
        at_s(65); load = 1'b0;
        wait_until(base + 657);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check("arst_clk_out", clk_out, 0);
        check("arst_active", active, 0);
        check("arst_cur_ratio", cur_ratio, 2);
        wait_until(base + 663);
        reset_n = 1'b1;
        wait_until(base + 685);
        check("post_rst_active", active, 0);
        check("post_rst_clk_out", clk_out, 0);
        check("post_rst_cur_ratio", cur_ratio, 2);

        // Discarded pending: restart must stay at ratio 2 with no ack.
        base = base + 700;
        at_s(0);  enable = 1'b1;
        exp_pulse(10, 0); exp_pulse(10, 20); exp_pulse(10, 20);
        at_s(5);  enable = 1'b0;
        at_s(8);  check("rerun_stop_active", active, 0);

        // In IDLE a load is adopted on the next edge.
        at_s(9);  load = 1'b1; div_ratio = 4'd4; ack_q.push_back(4);
        at_s(10); load = 1'b0;
        at_s(11); check("idle_adopt_ratio", cur_ratio, 4); check("idle_clk_out", clk_out, 0);

        at_s(14);
        check("pulses_left", pulse_q.size(), 0);
        check("acks_left", ack_q.size(), 0);
        check("errs_left", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
